// File: rtl/rename_register_file_pkg.sv
// Shared defaults and constants for the rename/future register file.
package rename_register_file_pkg;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_TAG_WIDTH  = 7;
  localparam int unsigned DEF_RF_WIDTH   = 5;
  localparam int unsigned DEF_IPC        = 2;
  localparam int unsigned DEF_CDB_COUNT  = 2;
  localparam int unsigned RF_X0          = 0;
endpackage

// File: rtl/rename_register_file_cdb_tag_match.sv
// Matches one tag against every CDB channel; the highest matching channel supplies data.
module cdb_tag_match
  import rename_register_file_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CDB_COUNT  = DEF_CDB_COUNT
) (
  input  logic [TAG_WIDTH-1:0]            tag,
  input  logic [CDB_COUNT-1:0]            broadcast_valid,
  input  logic [CDB_COUNT*TAG_WIDTH-1:0]  broadcast_tag,
  input  logic [CDB_COUNT*DATA_WIDTH-1:0] broadcast_data,
  output logic                            hit,
  output logic [DATA_WIDTH-1:0]           data
);
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned c = 0; c < CDB_COUNT; c++) begin
      if (broadcast_valid[c] && broadcast_tag[c*TAG_WIDTH +: TAG_WIDTH] == tag) begin
        hit  = 1'b1;
        data = broadcast_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
endmodule

// File: rtl/rename_register_file.sv
// Future/rename register file with CDB commit, retired architectural copy and
// single-cycle flush recovery.
module rename_register_file
  import rename_register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int unsigned RF_WIDTH   = DEF_RF_WIDTH,
  parameter int unsigned IPC        = DEF_IPC,
  parameter int unsigned CDB_COUNT  = DEF_CDB_COUNT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            halt,
  input  logic                            allowDecode,
  input  logic                            flush,
  input  logic [IPC*2-1:0]                src_valid,
  input  logic [IPC-1:0]                  rd_valid,
  input  logic [IPC*RF_WIDTH-1:0]         rs1,
  input  logic [IPC*RF_WIDTH-1:0]         rs2,
  input  logic [IPC*RF_WIDTH-1:0]         rd,
  input  logic [IPC*TAG_WIDTH-1:0]        destinationTag,
  output logic [IPC*TAG_WIDTH-1:0]        rs1_tag,
  output logic [IPC*TAG_WIDTH-1:0]        rs2_tag,
  output logic [IPC-1:0]                  rs1_dataValid,
  output logic [IPC-1:0]                  rs2_dataValid,
  output logic [IPC*DATA_WIDTH-1:0]       rs1_data,
  output logic [IPC*DATA_WIDTH-1:0]       rs2_data,
  input  logic [CDB_COUNT-1:0]            broadcastValid,
  input  logic [CDB_COUNT*TAG_WIDTH-1:0]  broadcastTag,
  input  logic [CDB_COUNT*DATA_WIDTH-1:0] broadcastData,
  input  logic [IPC-1:0]                  retireValid,
  input  logic [IPC*RF_WIDTH-1:0]         retireRd,
  input  logic [IPC*DATA_WIDTH-1:0]       retireData
);
  localparam int unsigned NUM_REGS = 2**RF_WIDTH;
  localparam logic [RF_WIDTH-1:0] X0 = RF_WIDTH'(RF_X0);

  logic [DATA_WIDTH-1:0] fut_data  [NUM_REGS];
  logic [TAG_WIDTH-1:0]  fut_tag   [NUM_REGS];
  logic [NUM_REGS-1:0]   fut_valid;
  logic [DATA_WIDTH-1:0] arf_data  [NUM_REGS];
  logic [DATA_WIDTH-1:0] arf_next  [NUM_REGS];

  logic [NUM_REGS-1:0]   ent_hit;
  logic [DATA_WIDTH-1:0] ent_data  [NUM_REGS];
  logic [NUM_REGS-1:0]   renamed;

  logic [RF_WIDTH-1:0]   src_idx   [IPC][2];
  logic [RF_WIDTH-1:0]   rd_idx    [IPC];
  logic [TAG_WIDTH-1:0]  dest_tag  [IPC];

  logic [TAG_WIDTH-1:0]  nxt_tag   [IPC][2];
  logic                  nxt_dv    [IPC][2];
  logic [DATA_WIDTH-1:0] nxt_data  [IPC][2];
  logic [TAG_WIDTH-1:0]  out_tag   [IPC][2];
  logic                  out_dv    [IPC][2];
  logic [DATA_WIDTH-1:0] out_data  [IPC][2];
  logic                  op_hit    [IPC][2];
  logic [DATA_WIDTH-1:0] op_data   [IPC][2];

  logic decode_en;
  assign decode_en = ~halt & allowDecode;

  for (genvar e = 0; e < NUM_REGS; e++) begin : g_entry
    cdb_tag_match #(.TAG_WIDTH(TAG_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CDB_COUNT(CDB_COUNT)) u_match (
      .tag(fut_tag[e]), .broadcast_valid(broadcastValid), .broadcast_tag(broadcastTag),
      .broadcast_data(broadcastData), .hit(ent_hit[e]), .data(ent_data[e])
    );
  end

  for (genvar i = 0; i < IPC; i++) begin : g_slot
    assign src_idx[i][0] = rs1[i*RF_WIDTH +: RF_WIDTH];
    assign src_idx[i][1] = rs2[i*RF_WIDTH +: RF_WIDTH];
    assign rd_idx[i]     = rd[i*RF_WIDTH +: RF_WIDTH];
    assign dest_tag[i]   = destinationTag[i*TAG_WIDTH +: TAG_WIDTH];

    for (genvar s = 0; s < 2; s++) begin : g_op
      cdb_tag_match #(.TAG_WIDTH(TAG_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CDB_COUNT(CDB_COUNT)) u_match (
        .tag(out_tag[i][s]), .broadcast_valid(broadcastValid), .broadcast_tag(broadcastTag),
        .broadcast_data(broadcastData), .hit(op_hit[i][s]), .data(op_data[i][s])
      );
    end

    assign rs1_tag[i*TAG_WIDTH +: TAG_WIDTH]    = out_tag[i][0];
    assign rs2_tag[i*TAG_WIDTH +: TAG_WIDTH]    = out_tag[i][1];
    assign rs1_dataValid[i]                     = out_dv[i][0];
    assign rs2_dataValid[i]                     = out_dv[i][1];
    assign rs1_data[i*DATA_WIDTH +: DATA_WIDTH] = out_data[i][0];
    assign rs2_data[i*DATA_WIDTH +: DATA_WIDTH] = out_data[i][1];
  end

  // Architectural copy including this cycle's retires, so flush sees them too.
  always_comb begin
    for (int unsigned e = 0; e < NUM_REGS; e++) arf_next[e] = arf_data[e];
    for (int unsigned i = 0; i < IPC; i++) begin
      if (retireValid[i] && retireRd[i*RF_WIDTH +: RF_WIDTH] != X0)
        arf_next[retireRd[i*RF_WIDTH +: RF_WIDTH]] = retireData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    renamed = '0;
    if (decode_en) begin
      for (int unsigned i = 0; i < IPC; i++)
        if (rd_valid[i] && rd_idx[i] != X0) renamed[rd_idx[i]] = 1'b1;
    end
  end

  // Source lookup: entry state, then same-cycle CDB bypass, then older slots in the bundle.
  always_comb begin
    for (int unsigned i = 0; i < IPC; i++) begin
      for (int unsigned s = 0; s < 2; s++) begin
        nxt_tag[i][s]  = '0;
        nxt_dv[i][s]   = 1'b1;
        nxt_data[i][s] = '0;
        if (src_valid[i*2+s]) begin
          nxt_tag[i][s]  = fut_tag[src_idx[i][s]];
          nxt_dv[i][s]   = fut_valid[src_idx[i][s]];
          nxt_data[i][s] = fut_data[src_idx[i][s]];
          if (!fut_valid[src_idx[i][s]] && ent_hit[src_idx[i][s]]) begin
            nxt_dv[i][s]   = 1'b1;
            nxt_data[i][s] = ent_data[src_idx[i][s]];
          end
          for (int unsigned k = 0; k < i; k++) begin
            if (rd_valid[k] && rd_idx[k] != X0 && rd_idx[k] == src_idx[i][s]) begin
              nxt_tag[i][s]  = dest_tag[k];
              nxt_dv[i][s]   = 1'b0;
              nxt_data[i][s] = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < NUM_REGS; e++) begin
        fut_data[e] <= '0;
        fut_tag[e]  <= '0;
        arf_data[e] <= '0;
      end
      fut_valid <= '1;
    end else begin
      for (int unsigned e = 0; e < NUM_REGS; e++) arf_data[e] <= arf_next[e];
      if (flush) begin
        for (int unsigned e = 0; e < NUM_REGS; e++) begin
          fut_data[e] <= arf_next[e];
          fut_tag[e]  <= '0;
        end
        fut_valid <= '1;
      end else begin
        for (int unsigned e = 0; e < NUM_REGS; e++) begin
          if (!fut_valid[e] && ent_hit[e] && !renamed[e]) begin
            fut_data[e]  <= ent_data[e];
            fut_valid[e] <= 1'b1;
          end
        end
        if (decode_en) begin
          for (int unsigned i = 0; i < IPC; i++) begin
            if (rd_valid[i] && rd_idx[i] != X0) begin
              fut_tag[rd_idx[i]]   <= dest_tag[i];
              fut_valid[rd_idx[i]] <= 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < IPC; i++) begin
        for (int unsigned s = 0; s < 2; s++) begin
          out_tag[i][s]  <= '0;
          out_dv[i][s]   <= 1'b0;
          out_data[i][s] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < IPC; i++) begin
        for (int unsigned s = 0; s < 2; s++) begin
          if (flush) begin
            out_dv[i][s] <= 1'b0;
          end else if (decode_en) begin
            out_tag[i][s]  <= nxt_tag[i][s];
            out_dv[i][s]   <= nxt_dv[i][s];
            out_data[i][s] <= nxt_data[i][s];
          end else if (!out_dv[i][s] && op_hit[i][s]) begin
            out_dv[i][s]   <= 1'b1;
            out_data[i][s] <= op_data[i][s];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file: hand-computed expectations per step.
module tb_rename_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic        halt, allowDecode, flush;
  logic [3:0]  src_valid;
  logic [1:0]  rd_valid;
  logic [9:0]  rs1, rs2, rd;
  logic [13:0] destinationTag;
  logic [13:0] rs1_tag, rs2_tag;
  logic [1:0]  rs1_dataValid, rs2_dataValid;
  logic [63:0] rs1_data, rs2_data;
  logic [1:0]  broadcastValid;
  logic [13:0] broadcastTag;
  logic [63:0] broadcastData;
  logic [1:0]  retireValid;
  logic [9:0]  retireRd;
  logic [63:0] retireData;

  int tests = 0;
  int fails = 0;

  rename_register_file #(.DATA_WIDTH(32), .TAG_WIDTH(7), .RF_WIDTH(5), .IPC(2), .CDB_COUNT(2)) dut (
    .clk(clk), .rst(rst), .halt(halt), .allowDecode(allowDecode), .flush(flush),
    .src_valid(src_valid), .rd_valid(rd_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .destinationTag(destinationTag), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rs1_dataValid(rs1_dataValid), .rs2_dataValid(rs2_dataValid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .broadcastValid(broadcastValid),
    .broadcastTag(broadcastTag), .broadcastData(broadcastData),
    .retireValid(retireValid), .retireRd(retireRd), .retireData(retireData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    halt = 1'b0; allowDecode = 1'b0; flush = 1'b0;
    src_valid = '0; rd_valid = '0; rs1 = '0; rs2 = '0; rd = '0; destinationTag = '0;
    broadcastValid = '0; broadcastTag = '0; broadcastData = '0;
    retireValid = '0; retireRd = '0; retireData = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    chk("reset_rs1_dv", 64'(rs1_dataValid), 64'h0);
    chk("reset_rs2_dv", 64'(rs2_dataValid), 64'h0);
    chk("reset_tags", {36'h0, rs1_tag, rs2_tag}, 64'h0);
    chk("reset_data", rs1_data | rs2_data, 64'h0);
    rst = 1'b0;

    // Plain read: rs1=x5, rs2=x0 in slot 0; slot 1 sources unused.
    allowDecode = 1'b1; src_valid = 4'b0011; rs1[4:0] = 5'd5; rs2[4:0] = 5'd0;
    step();
    chk("read_x5_dv", 64'(rs1_dataValid[0]), 64'h1);
    chk("read_x5_data", 64'(rs1_data[31:0]), 64'h0);
    chk("read_x5_tag", 64'(rs1_tag[6:0]), 64'h0);
    chk("read_x0_dv", 64'(rs2_dataValid[0]), 64'h1);
    chk("unused_src_dv", 64'(rs1_dataValid[1]), 64'h1);
    chk("unused_src_data", 64'(rs2_data[63:32]), 64'h0);

    // Rename x3 -> 0x12, then read it.
    idle(); allowDecode = 1'b1; rd_valid = 2'b01; rd[4:0] = 5'd3; destinationTag[6:0] = 7'h12;
    step();
    idle(); allowDecode = 1'b1; src_valid = 4'b0001; rs1[4:0] = 5'd3;
    step();
    chk("renamed_x3_tag", 64'(rs1_tag[6:0]), 64'h12);
    chk("renamed_x3_dv", 64'(rs1_dataValid[0]), 64'h0);

    // Held output captures broadcast on channel 1.
    idle(); broadcastValid = 2'b10; broadcastTag[13:7] = 7'h12; broadcastData[63:32] = 32'hDEAD;
    step();
    chk("hold_capture_dv", 64'(rs1_dataValid[0]), 64'h1);
    chk("hold_capture_data", 64'(rs1_data[31:0]), 64'hDEAD);
    idle(); allowDecode = 1'b1; src_valid = 4'b0001; rs1[4:0] = 5'd3;
    step();
    chk("commit_x3_dv", 64'(rs1_dataValid[0]), 64'h1);
    chk("commit_x3_data", 64'(rs1_data[31:0]), 64'hDEAD);

    // Read-time bypass: x6 renamed to 0x40, read while 0x40 broadcasts on channel 0.
    idle(); allowDecode = 1'b1; rd_valid = 2'b01; rd[4:0] = 5'd6; destinationTag[6:0] = 7'h40;
    step();
    idle(); allowDecode = 1'b1; src_valid = 4'b0001; rs1[4:0] = 5'd6;
    broadcastValid = 2'b01; broadcastTag[6:0] = 7'h40; broadcastData[31:0] = 32'h1234;
    step();
    chk("bypass_dv", 64'(rs1_dataValid[0]), 64'h1);
    chk("bypass_data", 64'(rs1_data[31:0]), 64'h1234);

    // Intra-bundle dependency: slot 0 writes x7, slot 1 reads x7 twice.
    idle(); allowDecode = 1'b1; rd_valid = 2'b01; rd[4:0] = 5'd7; destinationTag[6:0] = 7'h20;
    src_valid = 4'b1100; rs1[9:5] = 5'd7; rs2[9:5] = 5'd7;
    step();
    chk("dep_rs1_tag", 64'(rs1_tag[13:7]), 64'h20);
    chk("dep_rs2_tag", 64'(rs2_tag[13:7]), 64'h20);
    chk("dep_rs1_dv", 64'(rs1_dataValid[1]), 64'h0);
    chk("dep_rs2_dv", 64'(rs2_dataValid[1]), 64'h0);

    // Rename beats same-cycle broadcast of the old tag.
    idle(); allowDecode = 1'b1; rd_valid = 2'b01; rd[4:0] = 5'd4; destinationTag[6:0] = 7'h2F;
    step();
    idle(); allowDecode = 1'b1; rd_valid = 2'b01; rd[4:0] = 5'd4; destinationTag[6:0] = 7'h30;
    broadcastValid = 2'b01; broadcastTag[6:0] = 7'h2F; broadcastData[31:0] = 32'h5555;
    step();
    idle(); allowDecode = 1'b1; src_valid = 4'b0001; rs1[4:0] = 5'd4;
    step();
    chk("rename_win_tag", 64'(rs1_tag[6:0]), 64'h30);
    chk("rename_win_dv", 64'(rs1_dataValid[0]), 64'h0);
    chk("rename_win_data", 64'(rs1_data[31:0]), 64'h0);

    // Halt freezes renames.
    idle(); halt = 1'b1; allowDecode = 1'b1; rd_valid = 2'b01; rd[4:0] = 5'd12; destinationTag[6:0] = 7'h50;
    step();
    idle(); allowDecode = 1'b1; src_valid = 4'b0001; rs1[4:0] = 5'd12;
    step();
    chk("halt_no_rename_dv", 64'(rs1_dataValid[0]), 64'h1);
    chk("halt_no_rename_tag", 64'(rs1_tag[6:0]), 64'h0);

    // Retire x9, retire x11 twice (slot 1 wins), rename x9, then flush with a retire of x10.
    idle(); retireValid = 2'b01; retireRd[4:0] = 5'd9; retireData[31:0] = 32'hAB;
    step();
    idle(); retireValid = 2'b11; retireRd = {5'd11, 5'd11}; retireData = {32'h2, 32'h1};
    step();
    idle(); allowDecode = 1'b1; rd_valid = 2'b01; rd[4:0] = 5'd9; destinationTag[6:0] = 7'h05;
    step();
    idle(); flush = 1'b1; allowDecode = 1'b1; src_valid = 4'b1111;
    retireValid = 2'b10; retireRd[9:5] = 5'd10; retireData[63:32] = 32'h77;
    step();
    chk("flush_rs1_dv", 64'(rs1_dataValid), 64'h0);
    chk("flush_rs2_dv", 64'(rs2_dataValid), 64'h0);
    idle(); allowDecode = 1'b1; src_valid = 4'b1111;
    rs1 = {5'd10, 5'd9}; rs2 = {5'd11, 5'd3};
    step();
    chk("flush_x9_dv", 64'(rs1_dataValid[0]), 64'h1);
    chk("flush_x9_data", 64'(rs1_data[31:0]), 64'hAB);
    chk("flush_x9_tag", 64'(rs1_tag[6:0]), 64'h0);
    chk("flush_x3_data", 64'(rs2_data[31:0]), 64'h0);
    chk("flush_retire_x10", 64'(rs1_data[63:32]), 64'h77);
    chk("retire_collision_x11", 64'(rs2_data[63:32]), 64'h2);

    // x0 is never renamed and never written.
    idle(); allowDecode = 1'b1; rd_valid = 2'b01; rd[4:0] = 5'd0; destinationTag[6:0] = 7'h11;
    src_valid = 4'b0100; rs1[9:5] = 5'd0;
    step();
    chk("x0_no_dep_dv", 64'(rs1_dataValid[1]), 64'h1);
    chk("x0_no_dep_tag", 64'(rs1_tag[13:7]), 64'h0);
    idle(); allowDecode = 1'b1; src_valid = 4'b0001; rs1[4:0] = 5'd0;
    broadcastValid = 2'b01; broadcastTag[6:0] = 7'h11; broadcastData[31:0] = 32'hFF;
    step();
    chk("x0_dv", 64'(rs1_dataValid[0]), 64'h1);
    chk("x0_data", 64'(rs1_data[31:0]), 64'h0);

    // Asynchronous reset mid-operation clears the architectural copy too.
    idle();
    #2 rst = 1'b1;
    #1;
    chk("async_reset_dv", 64'(rs1_dataValid), 64'h0);
    #1 rst = 1'b0;
    idle(); allowDecode = 1'b1; src_valid = 4'b0001; rs1[4:0] = 5'd9;
    step();
    idle(); flush = 1'b1;
    step();
    idle(); allowDecode = 1'b1; src_valid = 4'b0001; rs1[4:0] = 5'd9;
    step();
    chk("post_reset_x9_data", 64'(rs1_data[31:0]), 64'h0);
    chk("post_reset_x9_dv", 64'(rs1_dataValid[0]), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
